// File: rtl/nn_seq_pkg.sv
// Shared types for the layer output sequencer: FSM state encoding and counter width helper.
package nn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

  // $clog2(1) is 0, but the word counter always needs at least one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_output_sequencer_if.sv
// Capture bus, serialized output stream and status of the layer output sequencer.
// SEQ_ARGMAX_EN adds argmax / argmax_valid.
interface layer_output_sequencer_if #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
);
`ifdef SEQ_ARGMAX_EN
  localparam int CNT_W = nn_seq_pkg::clog2_min1(NN);
`endif

  logic [NN-1:0]           i_valid;
  logic [NN*dataWidth-1:0] i_data;
  logic                    out_ready;
  logic [dataWidth-1:0]    x_out;
  logic                    x_valid;
  logic                    busy;
  logic                    done;
  logic                    overflow;
`ifdef SEQ_ARGMAX_EN
  logic [CNT_W-1:0]        argmax;
  logic                    argmax_valid;

  modport master (input i_valid, i_data, out_ready,
                  output x_out, x_valid, busy, done, overflow, argmax, argmax_valid);
  modport slave  (output i_valid, i_data, out_ready,
                  input x_out, x_valid, busy, done, overflow, argmax, argmax_valid);
`else
  modport master (input i_valid, i_data, out_ready,
                  output x_out, x_valid, busy, done, overflow);
  modport slave  (output i_valid, i_data, out_ready,
                  input x_out, x_valid, busy, done, overflow);
`endif

endinterface

// File: rtl/seq_argmax.sv
// Running signed argmax over one streamed frame; result pulses one cycle after the last word.
// Only present when SEQ_ARGMAX_EN is defined.
`ifdef SEQ_ARGMAX_EN
module seq_argmax #(
  parameter int dataWidth = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] word,
  input  logic [CNT_W-1:0]     index,
  input  logic                 valid,
  input  logic                 last,
  output logic [CNT_W-1:0]     argmax,
  output logic                 argmax_valid
);

  logic signed [dataWidth-1:0] r_best;
  logic [CNT_W-1:0]            r_best_idx;
  logic [CNT_W-1:0]            r_final;
  logic                        r_pend;
  logic                        w_take;
  logic [CNT_W-1:0]            w_idx_now;

  // index 0 always restarts the search; strict '>' keeps the lowest index on ties
  assign w_take    = valid && ((index == '0) || ($signed(word) > r_best));
  assign w_idx_now = w_take ? index : r_best_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_best       <= '0;
      r_best_idx   <= '0;
      r_final      <= '0;
      r_pend       <= 1'b0;
      argmax       <= '0;
      argmax_valid <= 1'b0;
    end else begin
      r_pend       <= valid && last;
      argmax_valid <= r_pend;
      if (r_pend) argmax <= r_final;
      if (w_take) begin
        r_best     <= $signed(word);
        r_best_idx <= index;
      end
      if (valid && last) r_final <= w_idx_now;
    end
  end

endmodule
`endif

// File: rtl/layer_output_sequencer.sv
// Captures NN parallel neuron outputs into a buffer, then streams them one word per cycle.
// Optional feature macro: SEQ_ARGMAX_EN (signed argmax of each streamed frame).
module layer_output_sequencer
  import nn_seq_pkg::*;
#(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input logic                      clk,
  input logic                      rst,
  layer_output_sequencer_if.master bus
);

  localparam int CNT_W = clog2_min1(NN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NN - 1);

  state_t                        r_state, w_state_next;
  logic [NN-1:0]                 r_mask;
  logic [CNT_W-1:0]              r_cnt;
  logic [dataWidth-1:0]          r_buf [NN];
  logic [dataWidth-1:0]          r_x_out;
  logic                          r_x_valid;
  logic                          r_done;
  logic                          r_overflow;
  logic [NN-1:0][dataWidth-1:0]  w_word;
  logic                          w_capture;
  logic                          w_full;
  logic                          w_any;
  logic                          w_last;
  logic                          w_accept;

  assign w_word    = bus.i_data;
  assign w_capture = (r_state != SEND);
  assign w_full    = &(r_mask | bus.i_valid);
  assign w_any     = |bus.i_valid;
  assign w_last    = (r_cnt == LAST_IDX);
  assign w_accept  = (r_state == SEND) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_full) w_state_next = SEND;
               else if (w_any) w_state_next = CAPTURE;
      CAPTURE: if (w_full) w_state_next = SEND;
      SEND:    if (w_accept && w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // buffer has no reset: contents are only read after every bit of r_mask was set
  always_ff @(posedge clk) begin
    for (int k = 0; k < NN; k++) begin
      if (w_capture && bus.i_valid[k]) r_buf[k] <= w_word[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask     <= '0;
      r_cnt      <= '0;
      r_x_out    <= '0;
      r_x_valid  <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
      if (w_capture) begin
        r_mask <= r_mask | bus.i_valid;
        r_cnt  <= '0;
      end else begin
        if (w_any) r_overflow <= 1'b1;
        if (w_accept) begin
          r_x_out   <= r_buf[r_cnt];
          r_x_valid <= 1'b1;
          if (w_last) begin
            r_done <= 1'b1;
            r_mask <= '0;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.x_out    = r_x_out;
  assign bus.x_valid  = r_x_valid;
  assign bus.done     = r_done;
  assign bus.overflow = r_overflow;
  assign bus.busy     = (r_state != IDLE);

`ifdef SEQ_ARGMAX_EN
  seq_argmax #(
    .dataWidth (dataWidth),
    .CNT_W     (CNT_W)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .word         (r_buf[r_cnt]),
    .index        (r_cnt),
    .valid        (w_accept),
    .last         (w_last),
    .argmax       (bus.argmax),
    .argmax_valid (bus.argmax_valid)
  );
`endif

endmodule

// File: tb/tb_layer_output_sequencer.sv
// Directed + randomized bench for layer_output_sequencer against a queue-based frame model.
module tb_layer_output_sequencer;

  localparam int NN = 30;
  localparam int DW = 16;
  localparam int CW = $clog2(NN);

  logic clk = 1'b0;
  logic rst;
  logic [NN-1:0]         tb_valid;
  logic [NN-1:0][DW-1:0] tb_data;
  logic                  tb_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // frame-level reference state
  logic [DW-1:0] m_buf [NN];
  logic [NN-1:0] m_mask;
  logic          m_send;
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_xout;
  logic          m_ovf;
  int            m_am_frame, m_am_result, m_am_out;
  logic          m_am_due;

  always #5 clk = ~clk;

  layer_output_sequencer_if #(.NN(NN), .dataWidth(DW)) bus ();

  assign bus.i_valid   = tb_valid;
  assign bus.i_data    = tb_data;
  assign bus.out_ready = tb_ready;

  layer_output_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock: update the model with the inputs sampled at the edge, then compare
  task automatic tick();
    logic exp_valid, exp_done, exp_amv;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_amv   = 1'b0;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_send = 1'b0; m_mask = '0; m_q.delete(); m_xout = '0; m_ovf = 1'b0;
      m_am_due = 1'b0; m_am_out = 0;
    end else begin
      if (!m_send) begin
        for (int k = 0; k < NN; k++)
          if (tb_valid[k]) begin m_buf[k] = tb_data[k]; m_mask[k] = 1'b1; end
        if (&m_mask) begin
          m_send = 1'b1;
          m_mask = '0;
          m_q.delete();
          m_am_frame = 0;
          for (int k = 0; k < NN; k++) begin
            m_q.push_back(m_buf[k]);
            if ($signed(m_buf[k]) > $signed(m_buf[m_am_frame])) m_am_frame = k;
          end
        end
      end else begin
        if (|tb_valid) m_ovf = 1'b1;
        if (tb_ready) begin
          m_xout    = m_q.pop_front();
          exp_valid = 1'b1;
          if (m_q.size() == 0) begin exp_done = 1'b1; m_send = 1'b0; end
        end
      end
      exp_amv = m_am_due;
      if (m_am_due) m_am_out = m_am_result;
      m_am_due = exp_done;
      if (exp_done) m_am_result = m_am_frame;
    end
    #1;
    chk("x_valid",  32'(bus.x_valid),  32'(exp_valid));
    chk("x_out",    32'(bus.x_out),    32'(m_xout));
    chk("done",     32'(bus.done),     32'(exp_done));
    chk("busy",     32'(bus.busy),     32'(m_send || (|m_mask)));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef SEQ_ARGMAX_EN
    chk("argmax_valid", 32'(bus.argmax_valid), 32'(exp_amv));
    chk("argmax",       32'(bus.argmax),       32'(m_am_out));
`endif
  endtask

  task automatic rand_data();
    for (int k = 0; k < NN; k++) tb_data[k] = DW'($urandom);
  endtask

  // stream out the remainder of a frame; mode 0 ready=1, 1 toggling, 2 random
  task automatic drain(input int mode, input int maxc);
    int n;
    n = 0;
    tb_valid = '0;
    while (m_send && n < maxc) begin
      tb_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("drain_bound", 32'(m_send), 32'(0));
  endtask

  task automatic load_all();
    tb_valid = '1;
    tick();
    tb_valid = '0;
  endtask

  initial begin
    int c0, first_v, done_c, n;
    rst = 1'b1; tb_valid = '0; tb_data = '0; tb_ready = 1'b0;
    m_send = 1'b0; m_mask = '0; m_xout = '0; m_ovf = 1'b0;
    m_am_due = 1'b0; m_am_out = 0; m_am_frame = 0; m_am_result = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: all-at-once, word k = k+1, checking the latency and the done cycle
    for (int k = 0; k < NN; k++) tb_data[k] = DW'(k + 1);
    tb_ready = 1'b1;
    load_all();
    c0 = cyc; first_v = -1; done_c = -1;
    for (int i = 0; i < NN + 4; i++) begin
      tick();
      if (bus.x_valid === 1'b1 && first_v < 0) first_v = cyc;
      if (bus.done === 1'b1) done_c = cyc;
    end
    chk("t1_first_valid", 32'(first_v - c0), 32'(1));
    chk("t1_done_cycle",  32'(done_c - c0),  32'(NN));

    // 2: staggered, one new valid bit per cycle
    for (int k = 0; k < NN; k++) begin
      rand_data();
      tb_valid = NN'(1) << k;
      tick();
    end
    drain(0, 60);
    tick();

    // 3: backpressure toggling 1,0,1,0
    rand_data();
    load_all();
    drain(1, 100);
    tick();

    // 4: overflow on the 5th SEND cycle, then a normal staggered frame
    rand_data();
    tb_ready = 1'b1;
    load_all();
    for (int i = 0; i < 4; i++) tick();
    tb_valid = NN'(1);
    tb_data[0] = 16'hdead;
    tick();
    drain(0, 60);
    chk("t4_ovf_set", 32'(bus.overflow), 32'(1));
    for (int k = NN - 1; k >= 0; k--) begin
      rand_data();
      tb_valid = NN'(1) << k;
      tick();
    end
    drain(2, 200);
    chk("t4_ovf_sticky", 32'(bus.overflow), 32'(1));

    // 5: reset after 10 streamed words, then a fresh frame
    rand_data();
    tb_ready = 1'b1;
    load_all();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_busy", 32'(bus.busy), 32'(0));
    rand_data();
    load_all();
    drain(0, 60);
    tick();

`ifdef SEQ_ARGMAX_EN
    // 6: argmax with ties and an all-negative frame
    for (int k = 0; k < NN; k++) tb_data[k] = -16'sd100;
    tb_data[0] = 16'sd3; tb_data[1] = -16'sd7; tb_data[2] = 16'sd12;
    tb_data[3] = 16'sd12; tb_data[4] = 16'sd0;
    load_all();
    drain(0, 60);
    tick();
    chk("t6_argmax", 32'(bus.argmax), 32'(2));
    for (int k = 0; k < NN; k++) tb_data[k] = DW'(-1 - $urandom_range(1, 500));
    load_all();
    drain(0, 60);
    tick();
`endif

    // 7: random frames with random capture order, readiness and stray valids
    for (int f = 0; f < 8; f++) begin
      n = 0;
      while (!m_send && n < 60) begin
        rand_data();
        tb_valid = (n >= 20) ? '1 : NN'($urandom & $urandom & $urandom);
        tb_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      while (m_send && n < 400) begin
        tb_valid = ($urandom_range(0, 15) == 0) ? NN'($urandom) : '0;
        tb_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      chk("t7_frame_bound", 32'(m_send), 32'(0));
      tb_valid = '0;
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
